mem_responder: RTL

Responder end of the CPU data-memory interface: a 16-word x 16-bit synchronous RAM that services read, write and clear requests from control_unit.
- Provides a registered read path with configurable latency.
- Provides a multi-cycle sequenced clear with a busy indication.
- Exposes a flattened debug view of the low words on slot, for the register/memory viewer.

---
 rtl/mem_responder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Responder side of the CPU data-memory interface: 16x16 RAM with registered reads,
// sequenced clear and a debug slot view. Optional macro: MEM_RESPONDER_WRITE_ACK_EN.
module mem_responder #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int SLOT_WORDS = 8,
  parameter int READ_LAT   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req,
  input  logic                         rw,
  input  logic                         clr,
  input  logic [ADDR_W-1:0]            address,
  input  logic signed [DATA_W-1:0]     data_in,
  output logic signed [DATA_W-1:0]     data_out,
  output logic                         out_valid,
  output logic                         busy,
  output logic [SLOT_WORDS*DATA_W-1:0] slot,
  output logic [1:0]                   dbg_state
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [DATA_W-1:0]   dout_d;
  logic                vld_d;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;
  logic                accept;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Handshake: a request is taken when req=1 and busy=0 at a rising edge; anything
  // presented while busy=1 is dropped with no side effect. busy depends only on state.
  assign busy      = (state_q != IDLE);
  assign accept    = req && !busy;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    dout_d  = data_out;
    vld_d   = 1'b0;
    we      = 1'b0;
    waddr   = address;
    wdata   = data_in;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (clr) begin
            state_d = CLEAR;
            ptr_d   = '0;
          end else if (rw) begin
            we = 1'b1;
`ifdef MEM_RESPONDER_WRITE_ACK_EN
            vld_d = 1'b1;
`endif
          end else if (READ_LAT == 1) begin
            dout_d = mem[address];
            vld_d  = 1'b1;
          end else begin
            // Word is captured now so later writes cannot affect the returned value.
            hold_d  = mem[address];
            cnt_d   = CNT_W'(READ_LAT - 1);
            state_d = READ;
          end
        end
      end
      READ: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          dout_d  = hold_q;
          vld_d   = 1'b1;
          state_d = IDLE;
        end
      end
      CLEAR: begin
        we    = 1'b1;
        waddr = ptr_q;
        wdata = '0;
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
`ifdef MEM_RESPONDER_WRITE_ACK_EN
          vld_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      data_out  <= dout_d;
      out_valid <= vld_d;
      if (we) mem[waddr] <= wdata;
    end
  end

  for (genvar i = 0; i < SLOT_WORDS; i++) begin : g_slot
    assign slot[i*DATA_W +: DATA_W] = mem[i];
  end

endmodule
